// File: rtl/spi_req_arbiter.sv
// Two-port round-robin arbiter in front of a single SPI engine.
// Handles grant, engine handshake with timeout, completion reporting and the mandatory idle gap.
module spi_req_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0,
    input  logic [31:0] tx0,
    output logic        done0,
    input  logic        req1,
    input  logic [31:0] tx1,
    output logic        done1,
    output logic [31:0] rx_data,
    output logic        err,
    output logic        busy,
    output logic        eng_start,
    output logic [31:0] eng_tx,
    input  logic        eng_done,
    input  logic [31:0] eng_rx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // WAIT is entered one cycle after eng_start, so the last WAIT cycle carries count TIMEOUT-2.
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 2);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] eng_tx_q, eng_tx_d;
    logic [31:0] rx_q, rx_d;
    logic        err_q, err_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic        grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            eng_tx_q <= '0;
            rx_q     <= '0;
            err_q    <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            eng_tx_q <= eng_tx_d;
            rx_q     <= rx_d;
            err_q    <= err_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        eng_tx_d = eng_tx_q;
        rx_d     = rx_q;
        err_d    = err_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // last_q holds the port served most recently; a tie goes to the other one.
                    grant    = (req0 && req1) ? ~last_q : req1;
                    owner_d  = grant;
                    eng_tx_d = grant ? tx1 : tx0;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done || (cnt_q == TO_LAST)) begin
                    rx_d    = eng_done ? eng_rx : 32'd0;
                    err_d   = ~eng_done;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    last_d  = owner_q;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign eng_start = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign eng_tx    = eng_tx_q;
    assign rx_data   = rx_q;
    assign err       = err_q;
    assign done0     = done0_q;
    assign done1     = done1_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed and randomized bench for spi_req_arbiter; two instances cover a long and a short timeout.
module tb_spi_req_arbiter;

    localparam int GA = 4;
    localparam int TA = 1024;
    localparam int GB = 2;
    localparam int TB = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] tx0 = '0;
    logic [31:0] tx1 = '0;
    logic        eng_done = 1'b0;
    logic [31:0] eng_rx = '0;

    logic        a_done0, a_done1, a_err, a_busy, a_start;
    logic [31:0] a_rx, a_tx;
    logic        b_done0, b_done1, b_err, b_busy, b_start;
    logic [31:0] b_rx, b_tx;

    logic        o_done0, o_done1, o_err, o_busy, o_start;
    logic [31:0] o_rx, o_tx;

    bit          sel = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          last_srv = 1;
    logic [31:0] m_rx = '0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    spi_req_arbiter #(.GAP_CYCLES(GA), .TIMEOUT(TA)) dut_a (
        .clk(clk), .rstn(rstn),
        .req0(req0), .tx0(tx0), .done0(a_done0),
        .req1(req1), .tx1(tx1), .done1(a_done1),
        .rx_data(a_rx), .err(a_err), .busy(a_busy),
        .eng_start(a_start), .eng_tx(a_tx), .eng_done(eng_done), .eng_rx(eng_rx)
    );

    spi_req_arbiter #(.GAP_CYCLES(GB), .TIMEOUT(TB)) dut_b (
        .clk(clk), .rstn(rstn),
        .req0(req0), .tx0(tx0), .done0(b_done0),
        .req1(req1), .tx1(tx1), .done1(b_done1),
        .rx_data(b_rx), .err(b_err), .busy(b_busy),
        .eng_start(b_start), .eng_tx(b_tx), .eng_done(eng_done), .eng_rx(eng_rx)
    );

    assign o_done0 = sel ? b_done0 : a_done0;
    assign o_done1 = sel ? b_done1 : a_done1;
    assign o_err   = sel ? b_err   : a_err;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_start = sel ? b_start : a_start;
    assign o_rx    = sel ? b_rx    : a_rx;
    assign o_tx    = sel ? b_tx    : a_tx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int gapc();
        return sel ? GB : GA;
    endfunction

    function automatic int tmo();
        return sel ? TB : TA;
    endfunction

    // Round-robin rule: lone requester wins, a tie goes to whoever was not served last.
    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) return (last_srv == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    task automatic do_reset();
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        eng_done = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rst_start", o_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", {o_done1, o_done0}, 0);
        check("rst_rx", o_rx, 0);
        check("rst_err", o_err, 0);
        check("rst_tx", o_tx, 0);
        tick();
        tick();
        rstn = 1'b1;
        last_srv = 1;
        m_rx = '0;
        m_err = 1'b0;
        tick();
        check("post_rst_busy", o_busy, 0);
        check("post_rst_done", {o_done1, o_done0}, 0);
    endtask

    // d = cycles from eng_start to eng_done (0 = never); returns on the done cycle.
    task automatic run_xfer(input int p, input logic [31:0] w, input int d,
                            input logic [31:0] r, input int exp_wait, input bit spur, input bit scr);
        int  n;
        int  e;
        bit  acc;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_start && n < 40);
        check("eng_start_seen", o_start, 1);
        if (exp_wait > 0) check("grant_latency", n, exp_wait);
        check("eng_tx", o_tx, w);
        check("busy_start", o_busy, 1);
        check("done_in_start", {o_done1, o_done0}, 0);
        tx0 = $urandom;
        tx1 = $urandom;
        if (scr) begin
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
        end
        eng_done = spur;
        eng_rx = $urandom;
        acc = (d >= 1) && (d <= tmo() - 1);
        e = acc ? d + 1 : tmo();
        for (int k = 1; k <= e; k++) begin
            tick();
            check("start_single", o_start, 0);
            check("done_pulse", {o_done1, o_done0}, (k == e) ? (p ? 2 : 1) : 0);
            eng_done = (k == d);
            eng_rx = (k == d) ? r : $urandom;
        end
        m_rx = acc ? r : 32'd0;
        m_err = ~acc;
        last_srv = p;
        check("rx_data", o_rx, m_rx);
        check("err", o_err, m_err);
        check("eng_tx_hold", o_tx, w);
        check("busy_done", o_busy, 1);
    endtask

    task automatic gap_idle(input bit spur);
        for (int g = 1; g < gapc(); g++) begin
            tick();
            check("gap_busy", o_busy, 1);
            check("gap_done", {o_done1, o_done0}, 0);
            check("gap_start", o_start, 0);
            check("gap_rx_hold", o_rx, m_rx);
            check("gap_err_hold", o_err, m_err);
            eng_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            eng_rx = $urandom;
        end
        tick();
        check("idle_busy", o_busy, 0);
        check("idle_start", o_start, 0);
        check("idle_done", {o_done1, o_done0}, 0);
        check("idle_rx_hold", o_rx, m_rx);
        check("idle_err_hold", o_err, m_err);
        eng_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p;
        int          d;
        int          pat;
        logic [31:0] w;
        logic [31:0] r;

        // Long-timeout instance: basic transfer, alternating grants, request during gap.
        sel = 1'b0;
        do_reset();

        req0 = 1'b1;
        tx0 = 32'hA5A5A5A5;
        run_xfer(0, 32'hA5A5A5A5, 70, 32'h12345678, 1, 1'b0, 1'b0);
        req0 = 1'b0;
        gap_idle(1'b0);

        do_reset();
        for (int t = 0; t < 4; t++) begin
            req0 = 1'b1;
            req1 = 1'b1;
            tx0 = 32'h00000A00 + t;
            tx1 = 32'h00000B00 + t;
            p = pick(1'b1, 1'b1);
            w = p ? tx1 : tx0;
            run_xfer(p, w, 3 + t, 32'hC0DE0000 + t, (t == 0) ? 0 : 1, 1'b0, 1'b0);
            if (t < 3) gap_idle(1'b0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int g = 1; g < GA; g++) begin
            tick();
            check("pulse_gap_busy", o_busy, 1);
            req1 = (g == 1);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check("withdrawn_busy", o_busy, 0);
            check("withdrawn_start", o_start, 0);
        end

        // Short-timeout instance: timeout, boundary completion, reset mid-transfer, random traffic.
        sel = 1'b1;
        do_reset();
        req0 = 1'b1;
        tx0 = 32'h11112222;
        run_xfer(0, 32'h11112222, 5, 32'hCAFEF00D, 1, 1'b0, 1'b0);
        gap_idle(1'b0);
        tx0 = 32'h33334444;
        run_xfer(0, 32'h33334444, 0, 32'h0, 1, 1'b0, 1'b0);
        req0 = 1'b0;
        gap_idle(1'b0);

        req1 = 1'b1;
        tx1 = 32'h55556666;
        run_xfer(1, 32'h55556666, TB - 1, 32'h0BADBEEF, 1, 1'b0, 1'b0);
        gap_idle(1'b0);
        tx1 = 32'h77778888;
        run_xfer(1, 32'h77778888, TB, 32'hDEADDEAD, 1, 1'b0, 1'b0);
        gap_idle(1'b0);
        req1 = 1'b0;
        req0 = 1'b1;
        tx0 = 32'h9999AAAA;
        run_xfer(0, 32'h9999AAAA, 2, 32'h13579BDF, 1, 1'b1, 1'b0);
        req0 = 1'b0;
        gap_idle(1'b1);

        req1 = 1'b1;
        tx1 = 32'hBBBBCCCC;
        tick();
        check("mid_start", o_start, 1);
        req1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        for (int i = 0; i < TB + 2; i++) begin
            tick();
            check("no_done_after_rst", {o_done1, o_done0}, 0);
            check("idle_after_rst", o_busy, 0);
        end
        req0 = 1'b1;
        req1 = 1'b1;
        tx0 = 32'h0000F00D;
        tx1 = 32'h0000BEEF;
        run_xfer(pick(1'b1, 1'b1), 32'h0000F00D, 4, 32'h24681357, 1, 1'b0, 1'b0);
        gap_idle(1'b0);

        for (int i = 0; i < 40; i++) begin
            pat = $urandom_range(1, 3);
            req0 = pat[0];
            req1 = pat[1];
            tx0 = $urandom;
            tx1 = $urandom;
            p = pick(req0, req1);
            w = p ? tx1 : tx0;
            d = $urandom_range(0, TB + 2);
            r = $urandom;
            run_xfer(p, w, d, r, 1, 1'($urandom_range(0, 1)), 1'b1);
            gap_idle(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4, setting the minimum idle clk cycles between engine transfers (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 1024, setting the maximum clk cycles from eng_start to eng_done (legal 2..65535).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req0, input, 1, port-0 transfer request (level).
REQ-006 SHALL have port tx0, input, 32, port-0 word to send.
REQ-007 SHALL have port done0, output, 1, port-0 completion pulse.
REQ-008 SHALL have port req1, input, 1, port-1 transfer request (level).
REQ-009 SHALL have port tx1, input, 32, port-1 word to send.
REQ-010 SHALL have port done1, output, 1, port-1 completion pulse.
REQ-011 SHALL have port rx_data, output, 32, received word of the last completed transfer.
REQ-012 SHALL have port err, output, 1, timeout flag qualified by done0/done1.
REQ-013 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-014 SHALL have port eng_start, output, 1, single-cycle start to the SPI engine.
REQ-015 SHALL have port eng_tx, output, 32, word presented to the engine.
REQ-016 SHALL have port eng_done, input, 1, engine completion pulse.
REQ-017 SHALL have port eng_rx, input, 32, engine received word, valid with eng_done.

Function
REQ-018 SHALL implement states IDLE, START, WAIT and GAP.
REQ-019 SHALL, in IDLE with any req high, grant one port, latch its tx into eng_tx, record the owner and enter START on the next edge.
REQ-020 SHALL arbitrate round-robin: a single requester wins; with both requesting, the port not served last wins.
REQ-021 SHALL assert eng_start for exactly the one cycle spent in START, clear the timeout counter, then enter WAIT.
REQ-022 SHALL hold eng_tx stable from START until the next grant.
REQ-023 SHALL, in WAIT when eng_done is sampled high at cycle M, load rx_data from eng_rx, clear err, pulse the owner's done for one cycle at M+1, update the round-robin pointer and enter GAP.
REQ-024 SHALL, when TIMEOUT cycles elapse in WAIT without eng_done, set rx_data to 0 and err to 1, pulse the owner's done for one cycle, update the pointer and enter GAP.
REQ-025 SHALL, if eng_done coincides with the timeout cycle, treat the transfer as a normal completion with err=0.
REQ-026 SHALL remain in GAP for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-027 SHALL ignore eng_done outside WAIT.
REQ-028 SHALL hold rx_data and err until the next completion.
REQ-029 SHALL treat a req deasserted before grant as withdrawn; once granted, the transfer SHALL complete regardless of req.
REQ-030 SHALL never assert done0 and done1 in the same cycle.
REQ-031 SHALL give a latency of req sampled in IDLE at cycle N -> eng_start high at cycle N+1.

Reset
REQ-032 SHALL, on rstn low at any time including mid-transfer, asynchronously force state IDLE, eng_start=0, eng_tx=0, rx_data=0, err=0, done0=0, done1=0, busy=0, counters=0 and the round-robin pointer to favour port 0.
REQ-033 SHALL start in IDLE at the first edge after rstn rises; an interrupted transfer SHALL NOT produce a done.

Verification
REQ-034 SHALL be verified by this scenario: req0 with tx0=32'hA5A5A5A5, eng_done after 70 cycles with eng_rx=32'h12345678 -> eng_tx=A5A5A5A5, a single eng_start pulse, done0 one cycle later, rx_data=12345678, err=0.
REQ-035 SHALL be verified by this scenario: req0 and req1 both held for 4 transfers -> grants in order 0,1,0,1, with at least GAP_CYCLES busy cycles between eng_start pulses.
REQ-036 SHALL be verified by this scenario: eng_done never asserted with TIMEOUT=16 -> done pulses 16 cycles after eng_start, err=1, rx_data=0, then GAP and IDLE.
REQ-037 SHALL be verified by this scenario: eng_done on the exact timeout cycle -> err=0 and rx_data=eng_rx.
REQ-038 SHALL be verified by this scenario: rstn low during WAIT -> all outputs 0, no done, and port 0 granted first when req0 and req1 are both asserted after reset.
REQ-039 SHALL be verified by this scenario: req1 pulsed for 1 cycle during GAP, then dropped -> no grant and busy falls after the gap.
